// File: rtl/genera1_pkg.sv
// Shared definitions for genera1: FSM state encoding.
package genera1_pkg;

    // Walk through the word one bit per edge in SHIFT; DONE holds the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/genera1.sv
// genera1: serial thermometer-code generator. Turns a ones-count Cuenta into an N-bit
// word with that many ones packed toward the MSB, one bit per clock under Start/Fin.
// Optional macro GENERA1_SAT_EN adds output Sat, flagging a clamped request.
module genera1
    import genera1_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] Cuenta,
    input  logic          Start,
    output logic [N-1:0]  Q,
    output logic          Fin,
`ifdef GENERA1_SAT_EN
    output logic          Sat,
`endif
    output logic          Ocupado
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] NCW   = CW'(N);
    localparam logic [IW-1:0] ILAST = IW'(N - 1);

    state_t        r_state;
    logic [N-1:0]  r_q;
    logic [CW-1:0] r_rem;
    logic [IW-1:0] r_idx;
    logic          r_fin;
    logic          r_ocupado;
    logic          w_over;
    logic [CW-1:0] w_clamp;
`ifdef GENERA1_SAT_EN
    logic          r_sat;
`endif

    // Requests above N saturate to an all-ones word.
    always_comb begin
        w_over  = (Cuenta > NCW);
        w_clamp = w_over ? NCW : Cuenta;
    end

    // FSM, shift register and down-counter; all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_q       <= '0;
            r_rem     <= '0;
            r_idx     <= '0;
            r_fin     <= 1'b0;
            r_ocupado <= 1'b0;
`ifdef GENERA1_SAT_EN
            r_sat     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (Start) begin
                        r_rem     <= w_clamp;
                        r_idx     <= '0;
                        r_q       <= '0;
                        r_fin     <= 1'b0;
                        r_ocupado <= 1'b1;
                        r_state   <= SHIFT;
`ifdef GENERA1_SAT_EN
                        r_sat     <= w_over;
`endif
                    end
                end
                SHIFT: begin
                    // Ones go in first, so they end up in the MSBs after N shifts.
                    r_q <= {r_q[N-2:0], (r_rem != '0)};
                    if (r_rem != '0) begin
                        r_rem <= r_rem - CW'(1);
                    end
                    if (r_idx == ILAST) begin
                        r_idx     <= '0;
                        r_fin     <= 1'b1;
                        r_ocupado <= 1'b0;
                        r_state   <= DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_ocupado <= 1'b0;
                    r_fin     <= 1'b0;
                end
            endcase
        end
    end

    // Drive outputs straight from registers.
    always_comb begin
        Q       = r_q;
        Fin     = r_fin;
        Ocupado = r_ocupado;
`ifdef GENERA1_SAT_EN
        Sat     = r_sat;
`endif
    end

endmodule

// File: tb/tb_genera1.sv
// Self-checking bench for genera1 (N=3, CW=4) against a thermometer-code model.
module tb_genera1;

    localparam int N  = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] cuenta;
    logic          start;
    logic [N-1:0]  q;
    logic          fin;
    logic          ocupado;
`ifdef GENERA1_SAT_EN
    logic          sat;
`endif

    int checks   = 0;
    int failures = 0;

    genera1 #(.N(N), .CW(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .Cuenta  (cuenta),
        .Start   (start),
        .Q       (q),
        .Fin     (fin),
`ifdef GENERA1_SAT_EN
        .Sat     (sat),
`endif
        .Ocupado (ocupado)
    );

    always #5 clk = ~clk;

    // Reference: number of ones after clamping, and the word with those ones in the MSBs.
    function automatic int model_count(input int c);
        return (c > N) ? N : c;
    endfunction

    function automatic logic [N-1:0] model_word(input int c);
        logic [N-1:0] w;
        w = '0;
        for (int b = 0; b < model_count(c); b++) w[N-1-b] = 1'b1;
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start pulse at one edge, then verify busy window, result, loopback count and hold.
    task automatic run_word(input int c, input bit check_sat);
        @(negedge clk);
        cuenta = CW'(c);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_first", {31'd0, ocupado}, 32'd1);
        check("fin_clear", {31'd0, fin}, 32'd0);
        for (int i = 1; i < N; i++) begin
            @(posedge clk); #1;
            check("busy_mid", {31'd0, ocupado}, 32'd1);
        end
        @(posedge clk); #1;
        check("fin_set", {31'd0, fin}, 32'd1);
        check("idle_after", {31'd0, ocupado}, 32'd0);
        check("q_word", 32'(q), 32'(model_word(c)));
        check("loopback", 32'($countones(q)), 32'(model_count(c)));
`ifdef GENERA1_SAT_EN
        if (check_sat) check("sat", {31'd0, sat}, {31'd0, (c > N)});
`else
        if (check_sat) check("sat_none", 32'(q), 32'(model_word(c)));
`endif
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
        end
        check("hold_q", 32'(q), 32'(model_word(c)));
        check("hold_fin", {31'd0, fin}, 32'd1);
    endtask

    initial begin
        int c;
        // Reset asserted at t=0 while Start is high.
        reset  = 1'b0;
        start  = 1'b1;
        cuenta = 4'd2;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", 32'(q), 32'd0);
        check("rst_fin", {31'd0, fin}, 32'd0);
        check("rst_busy", {31'd0, ocupado}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_accept", {31'd0, ocupado}, 32'd1);
        start = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        check("rst_word", 32'(q), 32'(model_word(2)));
        check("rst_wfin", {31'd0, fin}, 32'd1);

        // Sweep legal counts, then clamp, then a small run after clamp.
        for (int k = 0; k <= N; k++) run_word(k, 1'b0);
        run_word(15, 1'b1);
        run_word(1, 1'b1);

        // Random requests over the full input range.
        for (int r = 0; r < 6; r++) begin
            c = int'($urandom_range(0, 15));
            run_word(c, 1'b1);
        end

        // Busy: Start re-pulsed and Cuenta changed mid-SHIFT must be ignored.
        @(negedge clk);
        cuenta = 4'd0;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cuenta = 4'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        check("busy_ignore_q", 32'(q), 32'(model_word(0)));
        check("busy_ignore_fin", {31'd0, fin}, 32'd1);

        // Continuous Start: accepted at edge 0, Fin high once per N+1 edges.
        @(negedge clk);
        cuenta = 4'd2;
        start  = 1'b1;
        for (int j = 0; j < 4 * (N + 1); j++) begin
            @(posedge clk); #1;
            check("cont_fin", {31'd0, fin}, {31'd0, ((j % (N + 1)) == N)});
            if ((j % (N + 1)) == N) check("cont_q", 32'(q), 32'(model_word(2)));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (N + 2) @(posedge clk);

        // Abort: reset after one shifted bit clears everything at once.
        @(negedge clk);
        cuenta = 4'd3;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_q", 32'(q), 32'd0);
        check("abort_fin", {31'd0, fin}, 32'd0);
        check("abort_busy", {31'd0, ocupado}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_word(3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/genera1.md
Name: genera1

Overview:
- Inverse of the ones-counter (cuenta1): takes a ones-count `Cuenta` and produces an N-bit word `Q` containing exactly that many ones, packed toward the MSB (thermometer code).
- The word is built serially, one bit per clock, under the same Start/Fin multicycle handshake the counter uses.
- Used as a stimulus/loopback partner for cuenta1. Feeding genera1's `Q` into cuenta1 must return the original `Cuenta` (for values ≤ N).

Parameters:
- N, default 3: width of output word `Q` (≥ 2).
- CW, default 4: width of count input `Cuenta`. Must satisfy 2^CW > N.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Cuenta  input  CW  requested number of ones; sampled only on an accepted Start.
- Start  input  1  request; sampled on the rising clk edge; hold high for at least one edge.
- Q  output  N  generated word; valid while Fin=1.
- Fin  output  1  done flag; high from completion until the next accepted Start.
- Ocupado  output  1  high while the word is being built (state SHIFT).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, Q=0, Fin=0, Ocupado=0, internal counters=0.
  - Reset asserted mid-operation aborts immediately. No partial completion is reported.
- States: IDLE, SHIFT, DONE. Encoding comes from the shared package.
- Start acceptance:
  - Start=1 at an edge in IDLE or DONE is accepted.
  - On acceptance: rem <= min(Cuenta, N); idx <= 0; Q <= 0; Fin <= 0; state <= SHIFT.
  - Start in SHIFT is ignored. Cuenta changes in SHIFT are ignored.
- SHIFT, each edge:
  - Q <= {Q[N-2:0], (rem != 0)}
  - rem <= rem - 1 if rem != 0
  - idx <= idx + 1
  - On the edge where idx == N-1: Fin <= 1, state <= DONE.
- Latency: Start accepted at edge k → Fin=1 and Q final after edge k+N. Ocupado=1 during edges k..k+N-1.
- Result: Q has the rem ones in its MSBs. Examples for N=3: Cuenta 0→000, 1→100, 2→110, 3→111.
- Clamping: Cuenta > N is treated as N (Q all ones).
- DONE: Q and Fin are held stable indefinitely until reset or an accepted Start.
  - Start accepted in DONE clears Fin on that same edge (restart, no idle cycle).
- Width rules:
  - rem is CW bits; the comparison with N is made at CW bits.
  - idx is $clog2(N) bits and never exceeds N-1.
- Start held high continuously:
  - Accepted once, then ignored through SHIFT.
  - Re-accepted on the first edge in DONE, so Fin pulses high for exactly one cycle per word.

Optional Feature:
- Macro: GENERA1_SAT_EN.
- Defined:
  - Adds output port `Sat` (1 bit).
  - On acceptance, Sat <= (Cuenta > N). Sat holds its value until the next acceptance; reset value 0.
- Undefined:
  - No `Sat` port.
  - Clamping still applies silently.

Decomposition:
- Package genera1_pkg: state typedef/localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
- No sub-module. Shift register, down-counter and FSM are kept in one module (about 150 lines).

Test Plan:
- Reset: reset=0 at t=0 with Start=1 → Q=000, Fin=0, Ocupado=0. On release, Start is first accepted at the next edge.
- Basic (N=3): Cuenta=2, Start pulse at edge k → Ocupado=1 at edges k..k+2; after edge k+3, Q=110 and Fin=1; values held for ≥5 cycles.
- Sweep Cuenta=0..3, each word checked in loopback through cuenta1 → returned count equals input; Q = 000, 100, 110, 111.
- Clamp: Cuenta=4'b1111 → Q=111, Fin=1 after N edges. With GENERA1_SAT_EN, Sat=1; the next Cuenta=1 run gives Sat=0.
- Busy: Start re-pulsed and Cuenta changed 0→3 mid-SHIFT → ignored; result reflects the first Cuenta. Continuous Start=1 → Fin high one cycle per N+1.
- Abort: reset=0 during SHIFT after 1 bit → Q=000 and Fin=0 at once. A fresh Start completes normally.
